// File: rtl/mips_defs.sv
// Shared definitions for the ID-stage branch resolution slice.
// Pure package: no logic, no latency, no flow control.
// Holds FSM encodings, the zero-register id and jump-field width.
package mips_defs;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int REG_ZERO = 0;
  localparam int JIDX_W   = 26;

  // Hazard depth codes returned by branch_hazard_det.
  localparam logic [1:0] N_NONE = 2'd0;
  localparam logic [1:0] N_ONE  = 2'd1;
  localparam logic [1:0] N_TWO  = 2'd2;

  // One-hot ID decode bundled as a packed struct.
  typedef struct packed {
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
  } br_op_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_hazard_det.sv
// Branch-operand hazard depth (0/1/2 stall cycles) from EX/MEM destination info.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; the caller decides whether to act on the depth.
module branch_hazard_det
  import mips_defs::*;
#(
  parameter int rmsb = 4
) (
  input  logic [rmsb:0] rs,
  input  logic [rmsb:0] rt,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic          idex_regwrite,
  input  logic          idex_memread,
  input  logic [rmsb:0] idex_rd,
  input  logic          exmem_memread,
  input  logic [rmsb:0] exmem_rd,
  output logic [1:0]    n
);

  localparam logic [rmsb:0] ZERO = (rmsb+1)'(REG_ZERO);

  logic rs_live;
  logic rt_live;
  logic ex_match;
  logic mem_match;

  assign rs_live = use_rs && (rs != ZERO);
  assign rt_live = use_rt && (rt != ZERO);

  assign ex_match  = (rs_live && (rs == idex_rd))  || (rt_live && (rt == idex_rd));
  assign mem_match = (rs_live && (rs == exmem_rd)) || (rt_live && (rt == exmem_rd));

  // EX stage is younger, so its answer wins over MEM.
  always_comb begin
    n = N_NONE;
    if (ex_match && idex_memread) begin
      n = N_TWO;
    end else if (ex_match && idex_regwrite) begin
      n = N_ONE;
    end else if (mem_match && exmem_memread) begin
      n = N_ONE;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump resolution: stalls on operand hazards, then redirects PC and flushes IF/ID.
// Latency: Mealy outputs in the same cycle; EX load costs 2 stall cycles, EX ALU / MEM load 1.
// Backpressure: stall holds PC and IF/ID while bubble_idex feeds NOPs; BRANCH_STATS_EN builds the counters.
module branch_ctrl
  import mips_defs::*;
#(
  parameter int msb  = 31,
  parameter int rmsb = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              is_j,
  input  logic              is_jal,
  input  logic              is_jr,
  input  logic [rmsb:0]     rs,
  input  logic [rmsb:0]     rt,
  input  logic              f_iguales,
  input  logic [msb:0]      rs_val,
  input  logic [msb:0]      pc_plus4,
  input  logic [msb:0]      imm,
  input  logic [JIDX_W-1:0] instr_index,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [rmsb:0]     idex_rd,
  input  logic              exmem_memread,
  input  logic [rmsb:0]     exmem_rd,
  output logic              stall,
  output logic              bubble_idex,
  output logic              taken,
  output logic [msb:0]      target,
  output logic              flush_ifid,
  output logic [31:0]       n_branch,
  output logic [31:0]       n_taken,
  output logic [31:0]       n_stall
);

  br_op_t     op;
  state_t     state;
  state_t     state_nxt;
  logic       cnt;
  logic       cnt_nxt;
  logic [1:0] n;
  logic       branch_class;
  logic       any_op;
  logic       br_hazard;
  logic       resolve;
  logic       taken_c;
  logic [msb:0] br_tgt;
  logic [msb:0] jmp_tgt;
  logic [msb:0] tgt_sel;

  assign op           = '{beq: is_beq, bne: is_bne, j: is_j, jal: is_jal, jr: is_jr};
  assign branch_class = op.beq | op.bne | op.jr;
  assign any_op       = branch_class | op.j | op.jal;

  branch_hazard_det #(.rmsb(rmsb)) u_hazard (
    .rs            (rs),
    .rt            (rt),
    .use_rs        (branch_class),
    .use_rt        (op.beq | op.bne),
    .idex_regwrite (idex_regwrite),
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .exmem_memread (exmem_memread),
    .exmem_rd      (exmem_rd),
    .n             (n)
  );

  // Jumps never consult the hazard unit.
  assign br_hazard = valid_id && branch_class && (n != N_NONE);

  assign br_tgt  = pc_plus4 + (imm << 2);
  assign jmp_tgt = {pc_plus4[msb:msb-3], instr_index, 2'b00};

  always_comb begin
    tgt_sel = pc_plus4;
    if (op.beq || op.bne) begin
      tgt_sel = br_tgt;
    end else if (op.j || op.jal) begin
      tgt_sel = jmp_tgt;
    end else if (op.jr) begin
      tgt_sel = rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // STALL keeps counting regardless of valid_id and never re-checks hazards.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (br_hazard && (n == N_TWO)) begin
          state_nxt = ST_STALL;
          cnt_nxt   = 1'b1;
        end
      end
      ST_STALL: begin
        cnt_nxt = (cnt != 1'b0) ? cnt - 1'b1 : 1'b0;
        if (cnt_nxt == 1'b0) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    bubble_idex = 1'b0;
    resolve     = 1'b0;
    taken_c     = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (br_hazard) begin
            stall       = 1'b1;
            bubble_idex = 1'b1;
          end else if (valid_id && any_op) begin
            resolve = 1'b1;
            taken_c = (op.beq & f_iguales) | (op.bne & ~f_iguales) | op.j | op.jal | op.jr;
          end
        end
        ST_STALL: begin
          stall       = valid_id;
          bubble_idex = valid_id;
        end
        default: begin
          stall       = 1'b0;
          bubble_idex = 1'b0;
        end
      endcase
    end
  end

  assign taken      = taken_c;
  assign flush_ifid = taken_c;
  assign target     = reset ? '0 : (taken_c ? tgt_sel : pc_plus4);

`ifdef BRANCH_STATS_EN
  logic [31:0] n_branch_q;
  logic [31:0] n_taken_q;
  logic [31:0] n_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_branch_q <= '0;
      n_taken_q  <= '0;
      n_stall_q  <= '0;
    end else begin
      if (resolve) begin
        n_branch_q <= sat_inc(n_branch_q);
      end
      if (resolve && taken_c) begin
        n_taken_q <= sat_inc(n_taken_q);
      end
      if (stall) begin
        n_stall_q <= sat_inc(n_stall_q);
      end
    end
  end

  assign n_branch = reset ? '0 : n_branch_q;
  assign n_taken  = reset ? '0 : n_taken_q;
  assign n_stall  = reset ? '0 : n_stall_q;
`else
  assign n_branch = '0;
  assign n_taken  = '0;
  assign n_stall  = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector bench for branch_ctrl: single-cycle table plus multi-cycle stall/reset sequences.
module tb_branch_ctrl;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b01000;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00001;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        f;
    logic [31:0] rs_val;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [25:0] idx;
    logic        irw;
    logic        imr;
    logic [4:0]  ird;
    logic        emr;
    logic [4:0]  erd;
    logic [3:0]  exp_ctl;   // {stall, bubble_idex, taken, flush_ifid}
    logic [31:0] exp_tgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_id;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;
  logic [4:0]  rs, rt;
  logic        f_iguales;
  logic [31:0] rs_val, pc_plus4, imm;
  logic [25:0] instr_index;
  logic        idex_regwrite, idex_memread;
  logic [4:0]  idex_rd;
  logic        exmem_memread;
  logic [4:0]  exmem_rd;
  logic        stall, bubble_idex, taken, flush_ifid;
  logic [31:0] target;
  logic [31:0] n_branch, n_taken, n_stall;

  int total = 0;
  int bad   = 0;

  branch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .valid_id      (valid_id),
    .is_beq        (is_beq),
    .is_bne        (is_bne),
    .is_j          (is_j),
    .is_jal        (is_jal),
    .is_jr         (is_jr),
    .rs            (rs),
    .rt            (rt),
    .f_iguales     (f_iguales),
    .rs_val        (rs_val),
    .pc_plus4      (pc_plus4),
    .imm           (imm),
    .instr_index   (instr_index),
    .idex_regwrite (idex_regwrite),
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .exmem_memread (exmem_memread),
    .exmem_rd      (exmem_rd),
    .stall         (stall),
    .bubble_idex   (bubble_idex),
    .taken         (taken),
    .target        (target),
    .flush_ifid    (flush_ifid),
    .n_branch      (n_branch),
    .n_taken       (n_taken),
    .n_stall       (n_stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [4:0] op, input logic [4:0] rs_i,
                              input logic [4:0] rt_i, input logic f, input logic [31:0] rsv,
                              input logic [31:0] pc4, input logic [31:0] im, input logic [25:0] idx,
                              input logic irw, input logic imr, input logic [4:0] ird,
                              input logic emr, input logic [4:0] erd,
                              input logic [3:0] ctl, input logic [31:0] tgt);
    vec_t v;
    v.valid = valid; v.op = op; v.rs = rs_i; v.rt = rt_i; v.f = f; v.rs_val = rsv;
    v.pc4 = pc4; v.imm = im; v.idx = idx; v.irw = irw; v.imr = imr; v.ird = ird;
    v.emr = emr; v.erd = erd; v.exp_ctl = ctl; v.exp_tgt = tgt;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    valid_id      = v.valid;
    {is_beq, is_bne, is_j, is_jal, is_jr} = v.op;
    rs            = v.rs;
    rt            = v.rt;
    f_iguales     = v.f;
    rs_val        = v.rs_val;
    pc_plus4      = v.pc4;
    imm           = v.imm;
    instr_index   = v.idx;
    idex_regwrite = v.irw;
    idex_memread  = v.imr;
    idex_rd       = v.ird;
    exmem_memread = v.emr;
    exmem_rd      = v.erd;
  endtask

  task automatic check_out(input string name, input logic [3:0] ctl, input logic [31:0] tgt);
    total++;
    if ({stall, bubble_idex, taken, flush_ifid} !== ctl || target !== tgt) begin
      bad++;
      $display("FAIL %s: got ctl=%b target=%h, want ctl=%b target=%h",
               name, {stall, bubble_idex, taken, flush_ifid}, target, ctl, tgt);
    end
  endtask

  task automatic check_stats(input string name, input logic [31:0] eb, input logic [31:0] et,
                             input logic [31:0] es);
    total++;
    if (n_branch !== eb || n_taken !== et || n_stall !== es) begin
      bad++;
      $display("FAIL %s: got br=%0d tk=%0d st=%0d, want br=%0d tk=%0d st=%0d",
               name, n_branch, n_taken, n_stall, eb, et, es);
    end
  endtask

  // Drive on the falling edge, sample 2 ns later, well before the next rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    apply(v);
    #2;
  endtask

  vec_t tab[14];
  vec_t idle;
  vec_t v;

  initial begin
    idle = mk(1'b0, OP_NONE, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 26'h0,
              1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0000, 32'h0);

    tab[0]  = mk(1, OP_BEQ, 5'd1, 5'd2, 1, 32'h0, 32'h100, 32'h3, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0011, 32'h10C);
    tab[1]  = mk(1, OP_BNE, 5'd1, 5'd2, 1, 32'h0, 32'h200, 32'h3, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 32'h200);
    tab[2]  = mk(1, OP_BEQ, 5'd3, 5'd4, 0, 32'h0, 32'h100, 32'hFFFF_FFFF, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0000, 32'h100);
    tab[3]  = mk(1, OP_BNE, 5'd3, 5'd4, 0, 32'h0, 32'h1000, 32'hFFFF_FFFE, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0011, 32'hFF8);
    tab[4]  = mk(1, OP_J,   5'd5, 5'd6, 0, 32'h0, 32'h3000_0004, 32'h0, 26'h123456, 1, 1, 5'd5, 0, 5'd0, 4'b0011, 32'h3048_D158);
    tab[5]  = mk(1, OP_JAL, 5'd0, 5'd0, 0, 32'h0, 32'hF000_0000, 32'h0, 26'h3FF_FFFF, 0, 0, 5'd0, 0, 5'd0, 4'b0011, 32'hFFFF_FFFC);
    tab[6]  = mk(1, OP_JR,  5'd8, 5'd0, 0, 32'h0040_0020, 32'h300, 32'h0, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0011, 32'h0040_0020);
    tab[7]  = mk(1, OP_BEQ, 5'd0, 5'd0, 1, 32'h0, 32'h40, 32'h1, 26'h0, 1, 0, 5'd0, 0, 5'd0, 4'b0011, 32'h44);
    tab[8]  = mk(1, OP_BEQ, 5'd3, 5'd7, 1, 32'h0, 32'h80, 32'h1, 26'h0, 1, 0, 5'd7, 0, 5'd0, 4'b1100, 32'h80);
    tab[9]  = mk(0, OP_BEQ, 5'd5, 5'd6, 1, 32'h0, 32'h90, 32'h1, 26'h0, 1, 1, 5'd5, 0, 5'd0, 4'b0000, 32'h90);
    tab[10] = mk(1, OP_BEQ, 5'd3, 5'd9, 0, 32'h0, 32'hA0, 32'h1, 26'h0, 0, 0, 5'd0, 1, 5'd9, 4'b1100, 32'hA0);
    tab[11] = mk(1, OP_JR,  5'd8, 5'd9, 0, 32'h1234_5678, 32'hB0, 32'h0, 26'h0, 1, 1, 5'd9, 0, 5'd0, 4'b0011, 32'h1234_5678);
    tab[12] = mk(1, OP_BEQ, 5'd1, 5'd2, 1, 32'h0, 32'hFFFF_FFFC, 32'h1, 26'h0, 0, 0, 5'd0, 0, 5'd0, 4'b0011, 32'h0);
    tab[13] = mk(1, OP_NONE, 5'd8, 5'd9, 1, 32'h0, 32'hC0, 32'h1, 26'h0, 1, 1, 5'd8, 0, 5'd0, 4'b0000, 32'hC0);

    // Reset: a resolving beq on the inputs must not leak through.
    reset = 1'b1;
    apply(idle);
    step(tab[0]);
    check_out("reset_outputs", 4'b0000, 32'h0);
    check_stats("reset_stats", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tab[i]);
      check_out($sformatf("vec%0d", i), tab[i].exp_ctl, tab[i].exp_tgt);
    end

    // EX load on rs: two stall cycles, resolve in the third.
    @(negedge clk);
    reset = 1'b1;
    apply(idle);
    @(negedge clk);
    reset = 1'b0;
    v = mk(1, OP_BEQ, 5'd5, 5'd6, 1, 32'h0, 32'h500, 32'h2, 26'h0, 1, 1, 5'd5, 0, 5'd0, 4'b0, 32'h0);
    step(v);
    check_out("exload_c1", 4'b1100, 32'h500);
    v.irw = 0; v.imr = 0; v.ird = 5'd0; v.emr = 1; v.erd = 5'd5;
    step(v);
    check_out("exload_c2", 4'b1100, 32'h500);
    v.emr = 0; v.erd = 5'd0;
    step(v);
    check_out("exload_c3", 4'b0011, 32'h508);
    step(idle);
    check_out("exload_idle", 4'b0000, 32'h0);
    check_stats("exload_stats", STATS ? 32'd1 : 32'd0, STATS ? 32'd1 : 32'd0, STATS ? 32'd2 : 32'd0);

    // jr behind a MEM-stage load: one stall, then jump to rs_val.
    v = mk(1, OP_JR, 5'd8, 5'd0, 0, 32'h0040_0020, 32'h600, 32'h0, 26'h0, 0, 0, 5'd0, 1, 5'd8, 4'b0, 32'h0);
    step(v);
    check_out("jr_mem_c1", 4'b1100, 32'h600);
    v.emr = 0; v.erd = 5'd0;
    step(v);
    check_out("jr_mem_c2", 4'b0011, 32'h0040_0020);

    // valid_id low during STALL: no stall output, but the count still runs out.
    v = mk(1, OP_BNE, 5'd4, 5'd6, 0, 32'h0, 32'h700, 32'h4, 26'h0, 1, 1, 5'd6, 0, 5'd0, 4'b0, 32'h0);
    step(v);
    check_out("vlow_c1", 4'b1100, 32'h700);
    v.valid = 0; v.irw = 0; v.imr = 0; v.ird = 5'd0;
    step(v);
    check_out("vlow_c2", 4'b0000, 32'h700);
    v.valid = 1;
    step(v);
    check_out("vlow_c3", 4'b0011, 32'h710);

    // Reset during the first STALL cycle of an EX-load hazard.
    v = mk(1, OP_BEQ, 5'd5, 5'd6, 1, 32'h0, 32'h800, 32'h1, 26'h0, 1, 1, 5'd5, 0, 5'd0, 4'b0, 32'h0);
    step(v);
    check_out("rststall_c1", 4'b1100, 32'h800);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_out("rststall_rst", 4'b0000, 32'h0);
    check_stats("rststall_stats", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v.irw = 0; v.imr = 0; v.ird = 5'd0;
    apply(v);
    #2;
    check_out("rststall_after", 4'b0011, 32'h804);

    step(idle);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

ID-stage branch/jump resolution controller for the MIPS pipeline. It consumes the operand-equality flag produced beside the register file, detects branch-operand hazards, stalls for a counted number of cycles, then redirects the PC and flushes IF/ID. It sits between the hazard logic, the PC mux and the IF/ID/ID-EX pipeline registers.

## Interface
- `msb`, 31: MSB of PC/data words.
- `rmsb`, 4: MSB of register addresses.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_id` in 1: ID holds a valid instruction.
- `is_beq`, `is_bne`, `is_j`, `is_jal`, `is_jr` in 1 each: one-hot decode of the ID instruction (at most one high).
- `rs`, `rt` in rmsb+1: ID source register addresses.
- `f_iguales` in 1: 1 when forwarded rs and rt values are equal.
- `rs_val` in msb+1: forwarded rs value (jr target).
- `pc_plus4` in msb+1: PC+4 of the ID instruction.
- `imm` in msb+1: sign-extended 16-bit offset.
- `instr_index` in 26: jump field.
- `idex_regwrite`, `idex_memread` in 1; `idex_rd` in rmsb+1: EX-stage destination info.
- `exmem_memread` in 1; `exmem_rd` in rmsb+1: MEM-stage load destination.
- `stall` out 1: hold PC and IF/ID.
- `bubble_idex` out 1: insert NOP into ID/EX.
- `taken` out 1: select `target` at the PC mux.
- `target` out msb+1: redirect address.
- `flush_ifid` out 1: zero IF/ID on the next edge.
- `n_branch`, `n_taken`, `n_stall` out 32 each: statistics.

## Operation
- Branch-class instructions are beq, bne and jr. Beq and bne use rs and rt; jr uses rs only. Register 0 never causes a hazard.
- Hazard depth n:
  - EX load matching a used source: n=2.
  - EX ALU write (regwrite & !memread) matching: n=1.
  - Otherwise a MEM load matching: n=1.
  - Otherwise n=0.
  - EX checks take priority over MEM.
- FSM states RUN and STALL; 1-bit counter `cnt`.
- RUN, valid branch-class, n>0:
  - Assert stall and bubble_idex; taken=0.
  - If n=2, go to STALL with cnt=1. Otherwise stay in RUN.
- STALL:
  - Assert stall and bubble_idex; taken=0.
  - cnt is decremented. At cnt=0, return to RUN.
  - Hazards are not re-evaluated in STALL.
- RUN, n=0 (or j/jal, which are never hazards): resolve this cycle.
  - beq: taken=f_iguales.
  - bne: taken=!f_iguales.
  - j, jal, jr: taken=1.
- Targets:
  - beq/bne: pc_plus4 + (imm<<2), mod 2^32, overflow ignored.
  - j/jal: {pc_plus4[31:28], instr_index, 2'b00}.
  - jr: rs_val.
- flush_ifid = taken. There is no delay slot.
- When not taken: target = pc_plus4.
- When valid_id=0: no stall, no taken. The FSM stays in RUN, or keeps counting if already in STALL.

## Timing
- All outputs are 0 while reset is high. target is 0 during reset.
- State resets to RUN, cnt=0, statistics cleared.
- stall, bubble_idex, taken, target and flush_ifid are Mealy outputs, valid in the same cycle as the inputs.
- Stall lengths are counted from the first stall cycle:
  - EX load: 2 stall cycles, then resolve in the 3rd cycle.
  - EX ALU or MEM load: 1 stall cycle, resolve in the 2nd.
  - No hazard: 0 stall cycles.
- Reset asserted in STALL: RUN on the next edge, with no residual stall.
- stall and taken are never high in the same cycle.

## Configuration
- `BRANCH_STATS_EN` defined: three saturating 32-bit counters. They hold at 0xFFFFFFFF.
  - n_branch increments on each resolve of a branch-class or jump instruction.
  - n_taken increments on each resolve with taken=1.
  - n_stall increments on each cycle with stall=1.
- Undefined: the counters are not built and the ports are tied to 0.

## Structure
- The shared package/include `mips_defs` holds:
  - State encodings ST_RUN=1'b0 and ST_STALL=1'b1.
  - The REG_ZERO constant.
  - The jump-field width (26).
- One sub-module, `branch_hazard_det`: combinational. It takes the rs/rt/use flags and the EX/MEM info, and returns n (2 bits).
- The FSM, target adder and statistics counters live in the top module.

## Test plan
- beq, rs=rt values equal (f_iguales=1), pc_plus4=0x100, imm=0x3, no hazard -> same cycle taken=1, target=0x10C, flush_ifid=1, stall=0.
- bne with f_iguales=1, pc_plus4=0x200 -> taken=0, target=0x200, flush_ifid=0.
- beq with idex_memread=1, idex_rd=rs=5 -> stall=bubble_idex=1 for exactly 2 cycles, resolve on cycle 3; n_stall=2 (stats on).
- jr rs=8 with exmem_memread=1, exmem_rd=8 -> 1 stall cycle, then taken=1, target=rs_val=0x0040_0020.
- beq hazard with rd=0 (idex_regwrite=1, idex_rd=0, rs=0) -> no stall.
- Reset asserted in the first STALL cycle of an n=2 hazard -> outputs are 0 in the reset cycle; the next cycle, in RUN, evaluates normally, and a no-hazard beq resolves without stalling.
